// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit bridging the single-cycle datapath to a req/ack data bus
// Handles lane steering, load extension, alignment/size faults and bus timeout.
module riscv_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic [1:0]  o_err_cause,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  input  logic        m_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    size_q;
  logic          sign_q;
  logic [1:0]    off_q;

  logic [1:0]  size;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] lane;
  logic [31:0] rdata_ext;

  assign size = i_funct3[1:0];
  // Stores have no unsigned variants, so any funct3 above SW is illegal.
  assign illegal = i_we ? (i_funct3 > 3'd2)
                        : ((i_funct3[1:0] == 2'b11) || (i_funct3 == 3'b110));
  assign misaligned = ((size == 2'b01) && i_addr[0]) ||
                      ((size == 2'b10) && (i_addr[1:0] != 2'b00));

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = i_wdata;
    case (size)
      2'b00: begin
        be_c    = 4'b0001 << i_addr[1:0];
        wdata_c = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{i_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = i_wdata;
      end
    endcase
    if (!i_we) wdata_c = 32'h0;
  end

  // Halfword accesses are aligned, so the byte-offset shift also selects the half lane.
  assign lane = m_rdata >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   rdata_ext = {{24{sign_q & lane[7]}}, lane[7:0]};
      2'b01:   rdata_ext = {{16{sign_q & lane[15]}}, lane[15:0]};
      default: rdata_ext = m_rdata;
    endcase
  end

  assign o_stall = ((state == IDLE) && i_valid) || (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= 32'h0;
      m_be        <= 4'h0;
      m_wdata     <= 32'h0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_err_cause <= 2'b00;
      o_rdata     <= 32'h0;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      off_q       <= 2'b00;
    end else begin
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_err_cause <= 2'b00;
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (illegal || misaligned) begin
              state       <= RESP;
              o_done      <= 1'b1;
              o_err       <= 1'b1;
              o_err_cause <= illegal ? 2'b10 : 2'b01;
              o_rdata     <= 32'h0;
            end else begin
              state   <= BUSY;
              m_req   <= 1'b1;
              m_we    <= i_we;
              m_addr  <= {i_addr[31:2], 2'b00};
              m_be    <= be_c;
              m_wdata <= wdata_c;
              size_q  <= size;
              sign_q  <= ~i_funct3[2];
              off_q   <= i_addr[1:0];
              cnt     <= '0;
            end
          end
        end
        BUSY: begin
          if (m_ack) begin
            state  <= RESP;
            m_req  <= 1'b0;
            o_done <= 1'b1;
            if (m_err) begin
              o_err       <= 1'b1;
              o_err_cause <= 2'b11;
              o_rdata     <= 32'h0;
            end else if (!m_we) begin
              o_rdata <= rdata_ext;
            end
          end else if (cnt == CNT_LAST) begin
            state       <= RESP;
            m_req       <= 1'b0;
            o_done      <= 1'b1;
            o_err       <= 1'b1;
            o_err_cause <= 2'b11;
            o_rdata     <= 32'h0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit between the single-cycle datapath's ALU/register-file outputs and a handshaked data-memory bus. It replaces the zero-latency data memory with a request/acknowledge port and stalls the datapath's PC update until the access completes. It also handles:
- byte, halfword and word lane steering;
- load sign/zero extension;
- misalignment and illegal-size checks;
- bus timeout.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles in BUSY waiting for m_ack before aborting (must be ≥ 1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  datapath requests a memory operation this cycle (load or store instruction).
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  access size/sign: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW.
- i_addr  in  32  byte address (ALU output).
- i_wdata  in  32  store data (rs2).
- o_stall  out  1  hold PC/register write while high.
- o_done  out  1  one-cycle pulse: operation finished (success or fault).
- o_rdata  out  32  extended load result; valid while o_done=1 and load.
- o_err  out  1  one-cycle pulse with o_done on fault.
- o_err_cause  out  2  01 misaligned, 10 illegal funct3, 11 bus error/timeout; 00 otherwise.
- m_req  out  1  bus request, held until m_ack.
- m_we  out  1  bus write enable.
- m_addr  out  32  word-aligned address ({i_addr[31:2], 2'b00}).
- m_be  out  4  byte enables.
- m_wdata  out  32  lane-replicated store data.
- m_ack  in  1  bus completes access this cycle.
- m_rdata  in  32  read data, valid with m_ack.
- m_err  in  1  bus error, qualified by m_ack.

## Operation
FSM states: IDLE, BUSY, RESP.
- IDLE, i_valid=0: stay.
- IDLE, i_valid=1, i_funct3 illegal:
  - illegal funct3 values: loads 011/110/111; stores ≥ 011.
  - → RESP with cause 10; no bus request.
- IDLE, i_valid=1, legal but misaligned:
  - misaligned means halfword with addr[0]=1, or word with addr[1:0]≠00.
  - → RESP with cause 01; no bus request.
  - illegal funct3 takes priority over misalignment.
- IDLE, i_valid=1, legal and aligned: register m_addr, m_we, m_be, m_wdata, size, sign and addr[1:0]; clear timeout counter → BUSY.
- BUSY: m_req=1.
  - m_ack=1, m_err=0: capture the extended load result → RESP, no error.
  - m_ack=1, m_err=1: → RESP with cause 11.
  - No ack and counter = TIMEOUT−1: → RESP with cause 11.
  - Otherwise increment the counter.
- RESP: o_done=1 (with o_err/o_err_cause if faulted) → IDLE.

Byte enables and lanes (k = addr[1:0]):
- Byte: m_be = 1<<k; m_wdata = {4{wdata[7:0]}}.
- Half: m_be = 0011 (k=00) or 1100 (k=10); m_wdata = {2{wdata[15:0]}}.
- Word: m_be = 1111; m_wdata = wdata.
- Loads drive the same m_be; m_wdata = 0 for loads.

Load extraction:
- Byte: m_rdata[8k+7:8k].
- Half: m_rdata[16·k[1]+15 : 16·k[1]].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.

Other rules:
- o_rdata holds its last value outside RESP. It is 0 after reset and 0 on any fault.
- o_stall = (IDLE & i_valid) | BUSY. It is 0 in RESP, so the datapath commits in the RESP cycle.

## Timing
- Reset (rst sampled high at an edge): state IDLE and counter 0. These outputs are 0: m_req, m_we, m_addr, m_be, m_wdata, o_done, o_err, o_err_cause, o_rdata.
- Reset in BUSY: m_req deasserts after that edge; any later m_ack is ignored.
- m_req, m_addr, m_be, m_wdata and m_we are registered. They are stable from the first BUSY cycle until the cycle after m_ack.
- m_ack is sampled only in BUSY; ack in IDLE/RESP is ignored.
- Latency, i_valid to o_done:
  - zero-wait bus (ack in the first BUSY cycle): 3 cycles (IDLE accept, BUSY, RESP);
  - N wait cycles: 3+N;
  - faults detected in IDLE: 2 cycles;
  - timeout: o_done in cycle TIMEOUT+2.
- Back-to-back: a new i_valid is accepted in the IDLE cycle immediately after RESP.
- The counter width is ceil(log2(TIMEOUT+1)) bits; it saturates and never wraps.

## Test plan
- LW at 0x0000_0104, ack in the first BUSY cycle with m_rdata=0xDEAD_BEEF:
  - bus side: m_be=1111, m_addr=0x104;
  - o_done 3 cycles after i_valid, o_rdata=0xDEAD_BEEF;
  - o_stall high for exactly 2 cycles.
- LB vs LBU at 0x203, m_rdata=0x8000_0000, 2 wait cycles:
  - m_be=1000;
  - LB → o_rdata=0xFFFF_FF80; LBU → 0x0000_0080;
  - o_done at cycle 5.
- SH at 0x302, i_wdata=0x1234_ABCD: m_we=1, m_be=1100, m_wdata=0xABCD_ABCD, m_addr=0x300; o_err=0.
- Faults:
  - LW at 0x101 → o_done+o_err, cause 01, at cycle 2; m_req never asserted.
  - Store funct3=011 → cause 10.
- Bus faults:
  - No ack with TIMEOUT=16 → m_req high 16 cycles, then cause 11 and m_req drops.
  - m_ack with m_err=1 → cause 11, o_rdata=0.
- Reset in the 2nd BUSY cycle: m_req=0 after that edge; a late m_ack produces no o_done; next LW completes normally.
